glyph_lane_renderer: RTL and testbench



---
 rtl/glyph_lane_renderer.sv | 154 +++++++++++++++
 tb/tb_glyph_lane_renderer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glyph_lane_renderer.sv
// glyph_lane_renderer
// Renders NUM_LANES glyph bitmaps into a private back buffer, one glyph row
// per clock. The finished back buffer is then copied onto the framebuffer
// output in a single cycle, so scan-out never sees a partially drawn frame.
module glyph_lane_renderer #(
    parameter int NUM_LANES  = 3,
    parameter int FB_WIDTH   = 40,
    parameter int FB_HEIGHT  = 30,
    parameter int GLYPH_W    = 6,
    parameter int GLYPH_H    = 5,
    parameter int LANE_X0    = 6,
    parameter int LANE_PITCH = 10,
    parameter int Y_OFFSET   = 2,
    parameter int YPOS_W     = 5
) (
    input  logic                                   clock,
    input  logic                                   reset_n,
    input  logic                                   start,
    input  logic [NUM_LANES-1:0]                   lane_en,
    input  logic [NUM_LANES*GLYPH_W*GLYPH_H-1:0]   glyphs,
    input  logic [NUM_LANES*YPOS_W-1:0]            ypos,
    output logic                                   busy,
    output logic                                   done,
    output logic [FB_WIDTH*FB_HEIGHT-1:0]          framebuffer
);

    localparam int GLYPH_BITS = GLYPH_W * GLYPH_H;
    localparam int FB_BITS    = FB_WIDTH * FB_HEIGHT;
    localparam int LANE_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int ROW_W      = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
    // Target-row width: wide enough for the largest Y_OFFSET+ypos+row sum
    // and for FB_HEIGHT itself, so the clipping compare never wraps.
    localparam int RW_A       = YPOS_W + $clog2(Y_OFFSET + GLYPH_H + 1) + 1;
    localparam int RW_B       = $clog2(FB_HEIGHT + 1) + 1;
    localparam int RW         = (RW_A > RW_B) ? RW_A : RW_B;

    // Lanes must fit horizontally inside the framebuffer.
    if (LANE_X0 + (NUM_LANES - 1) * LANE_PITCH + GLYPH_W > FB_WIDTH) begin : g_width_check
        $error("glyph_lane_renderer: lanes exceed FB_WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DRAW  = 2'd2,
        S_SWAP  = 2'd3
    } state_t;

    state_t                 state_reg;
    logic [NUM_LANES-1:0]   lane_en_reg;
    logic [NUM_LANES*GLYPH_BITS-1:0] glyphs_reg;
    logic [NUM_LANES*YPOS_W-1:0]     ypos_reg;
    logic [LANE_W-1:0]      lane_reg;
    logic [ROW_W-1:0]       row_reg;
    logic [FB_BITS-1:0]     back_reg;

    // Per-lane views of the latched inputs and the current row word placed
    // at each lane's column offset.
    logic [GLYPH_BITS-1:0]  lane_glyph  [NUM_LANES];
    logic [YPOS_W-1:0]      lane_ypos   [NUM_LANES];
    logic [FB_WIDTH-1:0]    lane_placed [NUM_LANES];

    logic [GLYPH_BITS-1:0]  sel_glyph;
    logic [GLYPH_W-1:0]     row_word;
    logic [RW-1:0]          target_row;
    logic                   draw_hit;
    logic [FB_WIDTH-1:0]    placed_word;
    logic [FB_BITS-1:0]     back_draw;

    genvar gi;

    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        assign lane_glyph[gi]  = glyphs_reg[gi*GLYPH_BITS +: GLYPH_BITS];
        assign lane_ypos[gi]   = ypos_reg[gi*YPOS_W +: YPOS_W];
        assign lane_placed[gi] = FB_WIDTH'(row_word) << (LANE_X0 + gi * LANE_PITCH);
    end

    // Select the glyph row being drawn this cycle and decide whether it lands
    // inside the framebuffer (disabled lanes and rows below the bottom skip).
    always_comb begin
        sel_glyph   = lane_glyph[lane_reg];
        // Row 0 is the most significant word of the glyph.
        row_word    = GLYPH_W'(sel_glyph >> (GLYPH_W * (GLYPH_H - 1 - int'(row_reg))));
        target_row  = RW'(Y_OFFSET) + RW'(lane_ypos[lane_reg]) + RW'(row_reg);
        draw_hit    = lane_en_reg[lane_reg] && (target_row < RW'(FB_HEIGHT));
        placed_word = lane_placed[lane_reg];
    end

    // Each framebuffer row ORs in the placed word only when it is the target.
    for (gi = 0; gi < FB_HEIGHT; gi++) begin : g_row
        assign back_draw[gi*FB_WIDTH +: FB_WIDTH] =
            back_reg[gi*FB_WIDTH +: FB_WIDTH] |
            ((draw_hit && (target_row == RW'(gi))) ? placed_word : {FB_WIDTH{1'b0}});
    end

    // Render sequencer: IDLE -> CLEAR -> DRAW (lane-major) -> SWAP -> IDLE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= S_IDLE;
            lane_en_reg <= '0;
            glyphs_reg  <= '0;
            ypos_reg    <= '0;
            lane_reg    <= '0;
            row_reg     <= '0;
            back_reg    <= '0;
            framebuffer <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        lane_en_reg <= lane_en;
                        glyphs_reg  <= glyphs;
                        ypos_reg    <= ypos;
                        busy        <= 1'b1;
                        state_reg   <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    back_reg  <= '0;
                    lane_reg  <= '0;
                    row_reg   <= '0;
                    state_reg <= S_DRAW;
                end
                S_DRAW: begin
                    // Skipped rows still consume the cycle to keep latency fixed.
                    back_reg <= back_draw;
                    if (row_reg == ROW_W'(GLYPH_H - 1)) begin
                        row_reg <= '0;
                        if (lane_reg == LANE_W'(NUM_LANES - 1)) begin
                            state_reg <= S_SWAP;
                        end else begin
                            lane_reg <= lane_reg + 1'b1;
                        end
                    end else begin
                        row_reg <= row_reg + 1'b1;
                    end
                end
                S_SWAP: begin
                    framebuffer <= back_reg;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state_reg   <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_glyph_lane_renderer.sv
// Testbench for glyph_lane_renderer: directed and randomized frames checked
// against a pixel-level reference model of the rendering rules.
module tb_glyph_lane_renderer;

    localparam int NL  = 3;
    localparam int FW  = 40;
    localparam int FH  = 30;
    localparam int GW  = 6;
    localparam int GH  = 5;
    localparam int X0  = 6;
    localparam int PIT = 10;
    localparam int YOF = 2;
    localparam int YW  = 5;
    localparam int GB  = GW * GH;
    localparam int FBB = FW * FH;
    localparam int LAT = NL * GH + 2;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [NL-1:0]     lane_en = '0;
    logic [NL*GB-1:0]  glyphs = '0;
    logic [NL*YW-1:0]  ypos = '0;
    logic              busy;
    logic              done;
    logic [FBB-1:0]    framebuffer;

    int tests_run = 0;
    int tests_failed = 0;
    logic [FBB-1:0] model_fb = '0;

    glyph_lane_renderer dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .lane_en     (lane_en),
        .glyphs      (glyphs),
        .ypos        (ypos),
        .busy        (busy),
        .done        (done),
        .framebuffer (framebuffer)
    );

    always #5 clock = ~clock;

    // Reference: paint every enabled glyph pixel that lands on screen.
    function automatic logic [FBB-1:0] model(input logic [NL-1:0] en,
                                             input logic [NL*GB-1:0] g,
                                             input logic [NL*YW-1:0] y);
        logic [FBB-1:0] fb;
        fb = '0;
        for (int l = 0; l < NL; l++) begin
            for (int r = 0; r < GH; r++) begin
                for (int k = 0; k < GW; k++) begin
                    int tr;
                    tr = YOF + int'(y[l*YW +: YW]) + r;
                    if (en[l] && tr < FH && g[l*GB + (GH-1-r)*GW + k])
                        fb[tr*FW + X0 + l*PIT + k] = 1'b1;
                end
            end
        end
        return fb;
    endfunction

    function automatic int first_diff(input logic [FBB-1:0] a, input logic [FBB-1:0] b);
        for (int i = 0; i < FBB; i++) if (a[i] !== b[i]) return i;
        return -1;
    endfunction

    function automatic logic [NL*GB-1:0] rand_glyphs();
        logic [NL*GB-1:0] g;
        for (int l = 0; l < NL; l++) g[l*GB +: GB] = GB'($urandom);
        return g;
    endfunction

    function automatic logic [NL*YW-1:0] rand_ypos();
        logic [NL*YW-1:0] y;
        for (int l = 0; l < NL; l++) y[l*YW +: YW] = YW'($urandom_range(0, 31));
        return y;
    endfunction

    // Issue one start and follow it until done (bounded); reports latency,
    // busy behaviour and whether the old frame stayed visible meanwhile.
    task automatic run_frame(input logic [NL-1:0] en, input logic [NL*GB-1:0] g,
                             input logic [NL*YW-1:0] y, input logic [FBB-1:0] prev,
                             output int lat, output bit busy_ok, output bit held_ok);
        @(negedge clock);
        lane_en = en; glyphs = g; ypos = y; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        lat = -1; busy_ok = 1'b1; held_ok = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (done === 1'b1) begin
                lat = c;
                if (busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (framebuffer !== prev) held_ok = 1'b0;
            @(posedge clock); #1;
        end
        $display("[TB] frame lane_en=%b ypos=%h latency=%0d pop=%0d", en, y, lat, $countones(framebuffer));
    endtask

    task automatic test_reset();
        bit ok;
        logic [FBB-1:0] snap_fb;
        reset_n = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            lane_en = NL'($urandom); glyphs = rand_glyphs(); ypos = rand_ypos();
            start = 1'(($urandom & 1));
            @(posedge clock); #1;
            if (framebuffer !== '0 || busy !== 1'b0 || done !== 1'b0) ok = 1'b0;
        end
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL reset_hold: fb_pop=%0d busy=%b done=%b, required 0/0/0", $countones(framebuffer), busy, done);
        end
        @(negedge clock);
        start = 1'b0; reset_n = 1'b1;
        snap_fb = '0;
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            lane_en = NL'($urandom); glyphs = rand_glyphs(); ypos = rand_ypos();
            @(posedge clock); #1;
            if (framebuffer !== snap_fb || busy !== 1'b0 || done !== 1'b0) ok = 1'b0;
        end
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL reset_idle: fb_pop=%0d busy=%b done=%b, required 0/0/0", $countones(framebuffer), busy, done);
        end
        model_fb = '0;
        $display("[TB] reset checked");
    endtask

    task automatic test_single_lane();
        int lat; bit bok, hok;
        logic [NL*GB-1:0] g;
        logic [FBB-1:0] exp_fb;
        g = '0; g[GB-1:0] = '1;
        exp_fb = '0;
        for (int i = 0; i < 5; i++) for (int b = 86 + 40*i; b <= 91 + 40*i; b++) exp_fb[b] = 1'b1;
        run_frame(3'b001, g, '0, model_fb, lat, bok, hok);
        tests_run++;
        if (lat != LAT || !bok) begin
            tests_failed++;
            $display("FAIL single_timing: latency=%0d busy_ok=%b, required %0d/1", lat, bok, LAT);
        end
        tests_run++;
        if (framebuffer !== exp_fb || $countones(framebuffer) != 30) begin
            tests_failed++;
            $display("FAIL single_pixels: pop=%0d first_diff=%0d, required pop=30", $countones(framebuffer), first_diff(framebuffer, exp_fb));
        end
        model_fb = exp_fb;
    endtask

    task automatic test_orientation();
        int lat; bit bok, hok;
        logic [NL*GB-1:0] g;
        logic [FBB-1:0] exp_fb;
        g = '0; g[29] = 1'b1;
        exp_fb = '0; exp_fb[211] = 1'b1;
        run_frame(3'b001, g, 15'd3, model_fb, lat, bok, hok);
        tests_run++;
        if (framebuffer !== exp_fb || !hok) begin
            tests_failed++;
            $display("FAIL orient_top: pop=%0d first_diff=%0d held=%b, required only bit 211", $countones(framebuffer), first_diff(framebuffer, exp_fb), hok);
        end
        model_fb = exp_fb;
        g = '0; g[0] = 1'b1;
        exp_fb = '0; exp_fb[366] = 1'b1;
        run_frame(3'b001, g, 15'd3, model_fb, lat, bok, hok);
        tests_run++;
        if (framebuffer !== exp_fb) begin
            tests_failed++;
            $display("FAIL orient_bottom: pop=%0d first_diff=%0d, required only bit 366", $countones(framebuffer), first_diff(framebuffer, exp_fb));
        end
        model_fb = exp_fb;
    endtask

    task automatic test_clip_enable();
        int lat; bit bok, hok;
        logic [NL*GB-1:0] g;
        logic [NL*YW-1:0] y;
        logic [FBB-1:0] exp_fb;
        g = '0; g[2*GB-1:GB] = '1;
        y = '0; y[2*YW-1:YW] = 5'd25;
        exp_fb = '0;
        for (int r = 27; r <= 29; r++) for (int c = 16; c <= 21; c++) exp_fb[r*FW + c] = 1'b1;
        run_frame(3'b010, g, y, model_fb, lat, bok, hok);
        tests_run++;
        if (framebuffer !== exp_fb || $countones(framebuffer) != 18) begin
            tests_failed++;
            $display("FAIL clip_partial: pop=%0d first_diff=%0d, required pop=18", $countones(framebuffer), first_diff(framebuffer, exp_fb));
        end
        model_fb = exp_fb;
        y[2*YW-1:YW] = 5'd31;
        run_frame(3'b010, g, y, model_fb, lat, bok, hok);
        tests_run++;
        if (framebuffer !== '0 || lat != LAT) begin
            tests_failed++;
            $display("FAIL clip_full: pop=%0d latency=%0d, required 0/%0d", $countones(framebuffer), lat, LAT);
        end
        model_fb = '0;
        run_frame(3'b000, '1, '0, model_fb, lat, bok, hok);
        tests_run++;
        if (framebuffer !== '0 || lat != LAT || !bok) begin
            tests_failed++;
            $display("FAIL lanes_disabled: pop=%0d latency=%0d busy_ok=%b, required 0/%0d/1", $countones(framebuffer), lat, bok, LAT);
        end
    endtask

    task automatic test_random();
        int lat; bit bok, hok;
        logic [NL-1:0] en;
        logic [NL*GB-1:0] g;
        logic [NL*YW-1:0] y;
        logic [FBB-1:0] exp_fb;
        for (int i = 0; i < 10; i++) begin
            en = NL'($urandom); g = rand_glyphs(); y = rand_ypos();
            exp_fb = model(en, g, y);
            run_frame(en, g, y, model_fb, lat, bok, hok);
            tests_run++;
            if (framebuffer !== exp_fb || lat != LAT || !bok || !hok) begin
                tests_failed++;
                $display("FAIL random_%0d: pop=%0d first_diff=%0d latency=%0d busy_ok=%b held=%b, required pop=%0d latency=%0d",
                         i, $countones(framebuffer), first_diff(framebuffer, exp_fb), lat, bok, hok, $countones(exp_fb), LAT);
            end
            model_fb = exp_fb;
        end
    endtask

    task automatic test_handshake();
        int lat; bit bok, hok;
        int done_cnt, done_at;
        bit held;
        logic [NL*GB-1:0] ga, gb;
        logic [NL*YW-1:0] ya, yb;
        logic [FBB-1:0] fa, fbm;
        ga = rand_glyphs() | 90'h1; ya = '0;
        fa = model(3'b111, ga, ya);
        run_frame(3'b111, ga, ya, model_fb, lat, bok, hok);
        model_fb = fa;
        gb = rand_glyphs(); yb = rand_ypos();
        fbm = model(3'b111, gb, yb);
        @(negedge clock);
        lane_en = 3'b111; glyphs = gb; ypos = yb; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        done_cnt = 0; done_at = -1; held = 1'b1;
        for (int c = 0; c < 45; c++) begin
            if (c == 5) begin
                glyphs = ~gb; ypos = ~yb; lane_en = 3'b101; start = 1'b1;
            end
            if (c == 6) start = 1'b0;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (done_at < 0 && framebuffer !== fa) held = 1'b0;
            @(posedge clock); #1;
        end
        $display("[TB] handshake frame done_count=%0d latency=%0d", done_cnt, done_at);
        tests_run++;
        if (done_cnt != 1 || done_at != LAT) begin
            tests_failed++;
            $display("FAIL handshake_done: count=%0d at=%0d, required 1 at %0d", done_cnt, done_at, LAT);
        end
        tests_run++;
        if (!held) begin
            tests_failed++;
            $display("FAIL handshake_hold: held=0, required 1");
        end
        tests_run++;
        if (framebuffer !== fbm) begin
            tests_failed++;
            $display("FAIL handshake_latched: pop=%0d first_diff=%0d, required pop=%0d", $countones(framebuffer), first_diff(framebuffer, fbm), $countones(fbm));
        end
        model_fb = fbm;
    endtask

    task automatic test_mid_reset();
        int lat; bit bok, hok;
        logic [NL*GB-1:0] g;
        logic [NL*YW-1:0] y;
        logic [FBB-1:0] exp_fb;
        g = rand_glyphs() | 90'h1; y = '0;
        exp_fb = model(3'b111, g, y);
        run_frame(3'b111, g, y, model_fb, lat, bok, hok);
        model_fb = exp_fb;
        @(negedge clock);
        glyphs = rand_glyphs(); ypos = rand_ypos(); start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clock); #1;
        end
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (framebuffer !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset: pop=%0d busy=%b done=%b, required 0/0/0", $countones(framebuffer), busy, done);
        end
        model_fb = '0;
        @(negedge clock);
        reset_n = 1'b1;
        g = rand_glyphs(); y = rand_ypos();
        exp_fb = model(3'b111, g, y);
        run_frame(3'b111, g, y, model_fb, lat, bok, hok);
        tests_run++;
        if (framebuffer !== exp_fb || lat != LAT) begin
            tests_failed++;
            $display("FAIL after_reset: pop=%0d latency=%0d, required pop=%0d latency=%0d", $countones(framebuffer), lat, $countones(exp_fb), LAT);
        end
        model_fb = exp_fb;
    endtask

    initial begin
        test_reset();
        test_single_lane();
        test_orientation();
        test_clip_enable();
        test_random();
        test_handshake();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
